// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter state encoding
// and the UART data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_prio_sel.sv
// Combinational round-robin selector: returns the first asserted request at or
// after ptr, wrapping modulo N. Reusable for any shared resource.
module rr_prio_sel #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int pos;

  // Walk from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Optional tx_done watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [UART_DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]               ack,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_data_valid,
  input  logic                           tx_done,
  output logic [$clog2(N_REQ)-1:0]       grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic              wd_expired;
  logic              frame_end;

  rr_prio_sel #(.N(N_REQ), .IDX_W(IDX_W)) u_sel (
    .req   (req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk1) begin
    if (rst || state_q != WAIT_DONE) wd_cnt <= '0;
    else                             wd_cnt <= wd_cnt + 1'b1;
  end

  // tx_done arriving on the expiry cycle wins over the timeout.
  assign wd_expired = (state_q == WAIT_DONE) && !tx_done && (wd_cnt == WD_LAST);
`else
  // Watchdog compiled out: never expires.
  assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

  assign frame_end = (state_q == WAIT_DONE) && (tx_done || wd_expired);

  always_ff @(posedge clk1) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A fresh arbitration waits until the ack pulse has gone, so the acked
  // requester's still-high req is never mistaken for a new request.
  always_comb begin
    state_d       = state_q;
    tx_data_valid = (state_q == LAUNCH);
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE:      if (sel_valid && (ack == '0)) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (frame_end) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      ptr_q       <= '0;
      tx_data     <= '0;
      grant_id    <= '0;
      ack         <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      ack         <= '0;
      timeout_err <= wd_expired;
      gap_cnt     <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;
      if (state_q == IDLE && state_d == LAUNCH) begin
        tx_data  <= req_data[sel_idx*UART_DATA_W +: UART_DATA_W];
        grant_id <= sel_idx;
      end
      if (state_q == WAIT_DONE && tx_done)
        ack <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
      if (frame_end)
        ptr_q <= (grant_id == IDX_LAST) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized requester traffic against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TMO = 16;

  logic           clk1 = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk1          (clk1),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_done       (tx_done),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  // Reference model: pending requests, their bytes and the round-robin pointer.
  int         ptr;
  logic [N-1:0] pend;
  logic [7:0] dat [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    req = pend;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  endtask

  task automatic step();
    @(negedge clk1);
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(ack), 32'h0);
    check({tag, "_data"},  32'(tx_data), 32'h0);
    check({tag, "_valid"}, 32'(tx_data_valid), 32'h0);
    check({tag, "_grant"}, 32'(grant_id), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_tmo"},   32'(timeout_err), 32'h0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; tx_done = 1'b0; pend = '0; drive();
    step();
    check_reset_outputs("reset");
    step();
    rst = 1'b0; ptr = 0;
  endtask

  // Expect the launch pulse exactly n cycles from now, and not before.
  task automatic wait_launch(input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k < n) check("early_launch", 32'(tx_data_valid), 32'h0);
    end
    check("launch", 32'(tx_data_valid), 32'h1);
  endtask

  // Called on the launch cycle; serves the frame and returns on the ack cycle.
  // mode 0: quiet, 1: winner drops req and changes its byte, 2: random traffic.
  task automatic serve(input int n_wait, input int mode, output int w);
    logic [7:0] exp_byte;
    w = rr_pick();
    exp_byte = dat[w];
    check("grant_id", 32'(grant_id), 32'(w));
    check("tx_data", 32'(tx_data), 32'(exp_byte));
    check("busy_launch", 32'(busy), 32'h1);
    if (mode == 1 || (mode == 2 && $urandom_range(3) == 0)) begin
      pend[w] = 1'b0;
      dat[w]  = exp_byte ^ 8'($urandom_range(255, 1));
    end
    if (mode == 2)
      for (int i = 0; i < N; i++)
        if (i != w && !pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          dat[i]  = 8'($urandom);
        end
    drive();
    for (int k = 0; k < n_wait; k++) begin
      step();
      check("no_relaunch", 32'(tx_data_valid), 32'h0);
      check("hold_data", 32'(tx_data), 32'(exp_byte));
      check("early_ack", 32'(ack), 32'h0);
      check("no_timeout", 32'(timeout_err), 32'h0);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("ack", 32'(ack), 32'(1 << w));
    check("busy_gap", 32'(busy), 32'(GAP > 0));
    pend[w] = 1'b0;
    ptr = (w + 1) % N;
    drive();
  endtask

  // From the ack cycle with nothing pending: let the gap drain (with a stray
  // tx_done that must be ignored), then raise the requests in mask from IDLE.
  task automatic idle_request(input logic [N-1:0] mask);
    for (int k = 1; k <= GAP + 2; k++) begin
      step();
      tx_done = (k == 1);
      check("idle_no_launch", 32'(tx_data_valid), 32'h0);
      if (k == 2) check("stray_done_ack", 32'(ack), 32'h0);
    end
    check("idle_busy", 32'(busy), 32'h0);
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        pend[i] = 1'b1;
        dat[i]  = 8'($urandom);
      end
    drive();
    wait_launch(1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    pend = '0; ptr = 0; tx_done = 1'b0; rst = 1'b1; drive();

    // Single requester, byte A5, tx_done after 10 cycles.
    reset_dut();
    pend = 4'b0001; dat[0] = 8'hA5; drive();
    wait_launch(1);
    check("t1_byte", 32'(tx_data), 32'hA5);
    serve(10, 0, w);
    check("t1_winner", 32'(w), 32'h0);

    // All four requesting: strict order 0,1,2,3 with gap-spaced launches.
    reset_dut();
    pend = 4'b1111;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    drive();
    wait_launch(1);
    for (int i = 0; i < N; i++) begin
      check("t2_byte", 32'(tx_data), 32'(8'h11 * (i + 1)));
      serve(3, 0, w);
      check("t2_order", 32'(w), 32'(i));
      if (i < N - 1) wait_launch(GAP + 1);
    end

    // Pointer wrap: after granting 3, requesters 0 and 3 -> 0 then 3.
    idle_request(4'b1001);
    serve(2, 0, w);
    check("t3_first", 32'(w), 32'h0);
    wait_launch(GAP + 1);
    serve(2, 0, w);
    check("t3_second", 32'(w), 32'h3);

    // Requester 1 drops req and changes its byte mid-frame; ack still issued.
    idle_request(4'b0010);
    serve(6, 1, w);
    check("t4_winner", 32'(w), 32'h1);

`ifndef UART_ARB_TIMEOUT_EN
    // Without the watchdog a long wait for tx_done never raises timeout_err.
    idle_request(4'b0100);
    serve(20, 0, w);
`endif

    // Reset in WAIT_DONE aborts the frame with no ack.
    idle_request(4'b0010);
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1; pend = '0; drive();
    step();
    check_reset_outputs("t5_rst");
    rst = 1'b0; ptr = 0; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t5_no_ack", 32'(ack), 32'h0);
    step();
    check("t5_no_ack2", 32'(ack), 32'h0);
    pend = 4'b0100; dat[2] = 8'($urandom); drive();
    wait_launch(1);
    serve(4, 0, w);
    check("t5_winner", 32'(w), 32'h2);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no tx_done for TMO cycles -> timeout pulse, no ack, next requester.
    idle_request(4'b0011);
    w = rr_pick();
    for (int k = 1; k <= TMO; k++) begin
      step();
      check("t6_pre_tmo", 32'(timeout_err), 32'h0);
      check("t6_no_ack", 32'(ack), 32'h0);
    end
    step();
    check("t6_tmo", 32'(timeout_err), 32'h1);
    check("t6_tmo_ack", 32'(ack), 32'h0);
    ptr = (w + 1) % N;
    wait_launch(GAP + 1);
    serve(3, 0, w);
    check("t6_next", 32'(w), 32'h1);
    wait_launch(GAP + 1);
    serve(3, 0, w);
    check("t6_retry", 32'(w), 32'h0);
`endif

    // Randomized traffic against the round-robin model.
    for (int f = 0; f < 40; f++) begin
      if (pend == '0) idle_request(4'($urandom_range(15, 1)));
      else            wait_launch(GAP + 1);
      serve($urandom_range(12, 1), 2, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
